multichannel_decimator: RTL
===========================

Name: multichannel_decimator

Overview:
Parametrised multichannel decimator, the next generation of the standard decimator. It accepts an interleaved AXI-stream sample flow tagged by dest and reduces every N samples per channel to one output. The reduction mode is run-time selectable: drop, average, max or min. It supports per-channel independent accumulation, output backpressure and run-time clearing. It sits between ADC/filter front ends and the slower control or logging stages.

Parameters:
DATA_WIDTH, 16, sample width (signed two's complement)
MAX_CHANNELS, 8, number of independent channel states; dest values 0..MAX_CHANNELS-1
MAX_DECIMATION_RATIO, 16, largest supported ratio (power of two)
DEST_WIDTH, 8, width of the dest field on both streams

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
data_in  axi_stream slave  DATA_WIDTH/DEST_WIDTH  input samples; dest selects the channel
data_out  axi_stream master  DATA_WIDTH/DEST_WIDTH  decimated samples; dest is the channel index
decimation_ratio  in  $clog2(MAX_DECIMATION_RATIO)+1  N, samples per output
mode  in  2  0=drop (emit last sample), 1=average, 2=max, 3=min
clear  in  1  synchronous pulse; discards all partial blocks

Behaviour:
- Reset (async, active-high): data_out.valid=0, data_out.data=0, data_out.dest=0; all channel counters and accumulators are set to 0; data_in.ready=0 while reset is asserted.
- Handshake: data_in.ready = !data_out.valid || data_out.ready. A sample is accepted only when valid and ready are both high. data_out holds data/dest stable while valid && !ready.
- Per channel ch = data_in.dest:
  - count[ch] increments on each accepted sample.
  - acc[ch] update by mode: drop stores the sample; average adds the sample; max/min compare the sample with acc[ch].
  - The first sample of a block loads acc[ch] directly.
- Output condition: when count[ch] reaches the effective ratio N, an output is produced and count[ch] and acc[ch] are reset to the fresh-block state.
  - Latency: data_out.valid rises the cycle after the handshake of the Nth sample.
  - data_out.dest = ch.
- Throughput: one sample per clock. Channel state is held in register arrays with a single-cycle read-modify-write, so back-to-back samples on the same channel are legal.
- Arithmetic:
  - The accumulator is DATA_WIDTH+$clog2(MAX_DECIMATION_RATIO) bits, signed, and can never overflow.
  - Average result = acc >>> log2(N), truncating toward minus infinity.
  - Output is always DATA_WIDTH bits with no saturation needed.
- Ratio rules:
  - N=0 or 1: pass-through, each accepted sample is emitted with latency 1.
  - N > MAX_DECIMATION_RATIO is clamped to MAX.
  - Non-power-of-two N: block length is N, but the average shift is floor(log2 N) (documented limitation; software restricts average mode to powers of two).
- dest >= MAX_CHANNELS: the sample is accepted and discarded, with no state change.
- A change in decimation_ratio or mode, or clear=1, zeroes all counters next cycle. Partial blocks are discarded. A pending data_out beat is not affected. A sample accepted in the same cycle as clear is discarded.
- Reset mid-block: all partial results are lost and no output is emitted.

Optional Feature:
DECIMATOR_ROUNDING_EN
- Defined: average mode adds 2^(log2(N)-1) before the shift (round half up); no effect for N<=1 or in other modes.
- Undefined: plain truncating arithmetic shift. Max/min/drop are identical in both builds.

Decomposition:
- Package decimator_pkg: mode enum (DEC_DROP, DEC_AVERAGE, DEC_MAX, DEC_MIN), function returning log2 of a power-of-two ratio, accumulator width localparam helper.
- Sub-module decimator_reduction_unit:
  - Combinational combine of acc, sample and mode into next acc.
  - Final shift/rounding of the result.
  - Instantiated once and shared by all channels.

Test Plan:
- Average, N=4, dest 3: samples -10,-7,-3,4 -> one beat data=-4 (0xFFFC), dest=3, valid one cycle after the 4th handshake.
- Average, N=4: 4x0x7FFF -> 0x7FFF; 4x0x8000 -> 0x8000 (no overflow or wrap).
- Max, N=2: interleaved ch0 {1,9}, ch5 {-2,-8} -> outputs 9 (dest 0) then -2 (dest 5). Repeat in min mode -> 1 and -8.
- Backpressure: data_out.ready=0 with a beat pending -> data_in.ready=0 and data_out stable. Release -> beat consumed, next output follows with no lost samples.
- N=1 passes every sample through unchanged. Switch N 4->2 after 3 samples -> partial block discarded, next output after 2 new samples. Async reset asserted mid-block -> outputs 0 immediately, no spurious beat.
- Average, N=4, samples 1,1,1,0 -> output 0 without DECIMATOR_ROUNDING_EN, 1 with it.

Source files
------------

// File: rtl/multichannel_decimator_pkg.sv
//------------------------------------------------------------------------------
// Module   : decimator_pkg
// Purpose  : Shared types and helpers for the multichannel decimator.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package decimator_pkg;

  typedef enum logic [1:0] {
    DEC_DROP    = 2'd0,
    DEC_AVERAGE = 2'd1,
    DEC_MAX     = 2'd2,
    DEC_MIN     = 2'd3
  } dec_mode_e;

  localparam int c_shift_w = 5;

  // Accumulator must hold MAX_DECIMATION_RATIO full-scale samples without wrap.
  function automatic int dec_acc_width(input int data_width, input int max_ratio);
    return data_width + $clog2(max_ratio);
  endfunction

  // Floor of log2; exact for powers of two.
  function automatic logic [c_shift_w-1:0] dec_log2(input logic [31:0] n);
    logic [c_shift_w-1:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (n[i]) r = c_shift_w'(i);
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/multichannel_decimator_if.sv
//------------------------------------------------------------------------------
// Module   : axi_stream
// Purpose  : Minimal AXI-stream bundle (valid/ready/data/dest) with modports.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface axi_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int DEST_WIDTH = 8
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [DEST_WIDTH-1:0] dest;

  modport master (output valid, output data, output dest, input  ready);
  modport slave  (input  valid, input  data, input  dest, output ready);
endinterface

`default_nettype wire

// File: rtl/multichannel_decimator_reduction_unit.sv
//------------------------------------------------------------------------------
// Module   : decimator_reduction_unit
// Purpose  : Combines accumulator and sample per mode, and produces the final
//            output value. Optional macro: DECIMATOR_ROUNDING_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module decimator_reduction_unit
  import decimator_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 20
) (
  input  logic signed [ACC_WIDTH-1:0]  acc,
  input  logic signed [DATA_WIDTH-1:0] sample,
  input  dec_mode_e                    mode,
  input  logic                         first,
  input  logic [c_shift_w-1:0]         shift,
  output logic signed [ACC_WIDTH-1:0]  next_acc,
  output logic signed [DATA_WIDTH-1:0] result
);

  logic signed [ACC_WIDTH-1:0] w_sample_ext;
  logic signed [ACC_WIDTH-1:0] w_biased;

  assign w_sample_ext = {{(ACC_WIDTH-DATA_WIDTH){sample[DATA_WIDTH-1]}}, sample};

  always_comb begin
    next_acc = w_sample_ext;
    if (!first) begin
      case (mode)
        DEC_DROP:    next_acc = w_sample_ext;
        DEC_AVERAGE: next_acc = acc + w_sample_ext;
        DEC_MAX:     next_acc = (w_sample_ext > acc) ? w_sample_ext : acc;
        DEC_MIN:     next_acc = (w_sample_ext < acc) ? w_sample_ext : acc;
        default:     next_acc = w_sample_ext;
      endcase
    end
  end

  always_comb begin
    w_biased = next_acc;
`ifdef DECIMATOR_ROUNDING_EN
    // Round half up: bias by half an LSB of the shifted result.
    if (mode == DEC_AVERAGE && shift != '0)
      w_biased = next_acc + (ACC_WIDTH'(1) << (shift - 5'd1));
`endif
    result = DATA_WIDTH'((mode == DEC_AVERAGE) ? (w_biased >>> shift) : w_biased);
  end

endmodule

`default_nettype wire

// File: rtl/multichannel_decimator.sv
//------------------------------------------------------------------------------
// Module   : multichannel_decimator
// Purpose  : Per-channel N:1 decimator (drop/average/max/min) on an
//            interleaved AXI stream. Optional macro: DECIMATOR_ROUNDING_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multichannel_decimator
  import decimator_pkg::*;
#(
  parameter int DATA_WIDTH           = 16,
  parameter int MAX_CHANNELS         = 8,
  parameter int MAX_DECIMATION_RATIO = 16,
  parameter int DEST_WIDTH           = 8
) (
  input  logic                                  clock,
  input  logic                                  reset,
  axi_stream.slave                              data_in,
  axi_stream.master                             data_out,
  input  logic [$clog2(MAX_DECIMATION_RATIO):0] decimation_ratio,
  input  logic [1:0]                            mode,
  input  logic                                  clear
);

  localparam int c_acc_w   = dec_acc_width(DATA_WIDTH, MAX_DECIMATION_RATIO);
  localparam int c_ratio_w = $clog2(MAX_DECIMATION_RATIO) + 1;
  localparam int c_ch_w    = (MAX_CHANNELS > 1) ? $clog2(MAX_CHANNELS) : 1;

  logic [c_ratio_w-1:0]         r_count [MAX_CHANNELS];
  logic signed [c_acc_w-1:0]    r_acc   [MAX_CHANNELS];
  logic [c_ratio_w-1:0]         r_ratio;
  logic [1:0]                   r_mode;
  logic                         r_out_valid;
  logic [DATA_WIDTH-1:0]        r_out_data;
  logic [DEST_WIDTH-1:0]        r_out_dest;

  logic [c_ratio_w-1:0]         w_n_eff;
  logic [c_shift_w-1:0]         w_shift;
  logic                         w_ready;
  logic                         w_accept;
  logic                         w_flush;
  logic                         w_ch_ok;
  logic [c_ch_w-1:0]            w_ch;
  logic [c_ratio_w-1:0]         w_count;
  logic [c_ratio_w-1:0]         w_count_next;
  logic signed [c_acc_w-1:0]    w_acc;
  logic signed [c_acc_w-1:0]    w_acc_next;
  logic signed [DATA_WIDTH-1:0] w_result;
  logic                         w_update;
  logic                         w_emit;
  dec_mode_e                    w_mode;

  // Ratios 0 and 1 both mean pass-through; oversize ratios clamp to the max.
  always_comb begin
    w_n_eff = decimation_ratio;
    if (decimation_ratio == '0)
      w_n_eff = c_ratio_w'(1);
    else if (decimation_ratio > c_ratio_w'(MAX_DECIMATION_RATIO))
      w_n_eff = c_ratio_w'(MAX_DECIMATION_RATIO);
  end

  assign w_shift  = dec_log2(32'(w_n_eff));
  assign w_mode   = dec_mode_e'(mode);

  assign w_ready       = !reset && (!r_out_valid || data_out.ready);
  assign data_in.ready = w_ready;
  assign w_accept      = data_in.valid && w_ready;

  // A config change seen this cycle flushes every partial block; the sample
  // arriving alongside it belongs to neither block and is dropped.
  assign w_flush = clear || (decimation_ratio != r_ratio) || (mode != r_mode);

  assign w_ch_ok      = data_in.dest < DEST_WIDTH'(MAX_CHANNELS);
  assign w_ch         = data_in.dest[c_ch_w-1:0];
  assign w_count      = r_count[w_ch];
  assign w_acc        = r_acc[w_ch];
  assign w_count_next = w_count + 1'b1;
  assign w_emit       = w_count_next >= w_n_eff;
  assign w_update     = w_accept && w_ch_ok && !w_flush;

  decimator_reduction_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (c_acc_w)
  ) u_reduce (
    .acc      (w_acc),
    .sample   (data_in.data),
    .mode     (w_mode),
    .first    (w_count == '0),
    .shift    (w_shift),
    .next_acc (w_acc_next),
    .result   (w_result)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_CHANNELS; i++) begin
        r_count[i] <= '0;
        r_acc[i]   <= '0;
      end
      r_ratio <= '0;
      r_mode  <= '0;
    end else begin
      r_ratio <= decimation_ratio;
      r_mode  <= mode;
      if (w_flush) begin
        for (int i = 0; i < MAX_CHANNELS; i++) begin
          r_count[i] <= '0;
          r_acc[i]   <= '0;
        end
      end else if (w_update) begin
        if (w_emit) begin
          r_count[w_ch] <= '0;
          r_acc[w_ch]   <= '0;
        end else begin
          r_count[w_ch] <= w_count_next;
          r_acc[w_ch]   <= w_acc_next;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_dest  <= '0;
    end else if (w_update && w_emit) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_result;
      r_out_dest  <= data_in.dest;
    end else if (data_out.ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign data_out.valid = r_out_valid;
  assign data_out.data  = r_out_data;
  assign data_out.dest  = r_out_dest;

endmodule

`default_nettype wire
